// File: rtl/btb_ctrl_pkg.sv
// Shared types and helpers for the BTB update controller.
// Coalescing of queued updates is enabled by BTB_UPD_COALESCE_EN.
package btb_ctrl_pkg;

  localparam int PKG_PC_BITS = 32;

  typedef struct packed {
    logic [PKG_PC_BITS-1:0] orig_pc;
    logic [PKG_PC_BITS-1:0] target_pc;
  } btb_upd_t;

  typedef enum logic {
    IDLE,
    FLUSH
  } ctrl_state_e;

  function automatic logic [PKG_PC_BITS-1:0] line_idx(
    input logic [PKG_PC_BITS-1:0] pc,
    input int                     sel_bits
  );
    logic [PKG_PC_BITS-1:0] mask;
    mask = (PKG_PC_BITS'(1) << sel_bits) - PKG_PC_BITS'(1);
    return (pc >> 1) & mask;
  endfunction

endpackage

// File: rtl/btb_upd_queue.sv
// Searchable 2-in/1-out update queue with kill, compaction and
// optional in-place coalesce (BTB_UPD_COALESCE_EN).
module btb_upd_queue
  import btb_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   kill,
  input  logic [PKG_PC_BITS-1:0] kill_pc,
  input  logic                   pop,
  input  logic [1:0]             push,
  input  btb_upd_t [1:0]         push_data,
  output btb_upd_t               head,
  output logic                   head_valid,
  output logic [CW-1:0]          count
);

  btb_upd_t         q     [DEPTH];
  logic [DEPTH-1:0] v_q;
  btb_upd_t         surv  [DEPTH];
  int               ns;
  btb_upd_t         nxt   [DEPTH];
  logic [DEPTH-1:0] nxt_v;
  int               nn;
  logic             hit;

  // Survivors of this cycle's kill, compacted toward index 0.
  always_comb begin
    ns = 0;
    for (int i = 0; i < DEPTH; i++) surv[i] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (v_q[i] && !(kill && q[i].orig_pc == kill_pc)) begin
        surv[ns] = q[i];
        ns = ns + 1;
      end
    end
    head       = surv[0];
    head_valid = (ns != 0);
  end

  always_comb begin
    nn    = 0;
    nxt_v = '0;
    hit   = 1'b0;
    for (int i = 0; i < DEPTH; i++) nxt[i] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < ns && !(i == 0 && pop)) begin
        nxt[nn]   = surv[i];
        nxt_v[nn] = 1'b1;
        nn = nn + 1;
      end
    end
    // New updates are younger than the kill and land behind survivors.
    for (int s = 0; s < 2; s++) begin
      if (push[s]) begin
        hit = 1'b0;
`ifdef BTB_UPD_COALESCE_EN
        for (int i = 0; i < DEPTH; i++) begin
          if (nxt_v[i] &&
              nxt[i].orig_pc == push_data[s].orig_pc) begin
            nxt[i].target_pc = push_data[s].target_pc;
            hit = 1'b1;
          end
        end
`endif
        if (!hit && nn < DEPTH) begin
          nxt[nn]   = push_data[s];
          nxt_v[nn] = 1'b1;
          nn = nn + 1;
        end
      end
    end
    if (clear) nxt_v = '0;
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (v_q[i]) count = count + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) v_q <= '0;
    else     v_q <= nxt_v;
    for (int i = 0; i < DEPTH; i++) q[i] <= nxt[i];
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// Sequences BTB writes, invalidations and full-table flush sweeps.
// Optional coalescing of queued updates: BTB_UPD_COALESCE_EN.
module btb_update_ctrl
  import btb_ctrl_pkg::*;
#(
  parameter int PC_BITS     = 32,
  parameter int SIZE        = 1024,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             upd_valid,
  input  logic [1:0][PC_BITS-1:0] upd_orig_pc,
  input  logic [1:0][PC_BITS-1:0] upd_target_pc,
  output logic                   upd_ready,
  input  logic                   inv_valid,
  input  logic [PC_BITS-1:0]     inv_pc,
  input  logic                   flush_req,
  output logic                   flush_busy,
  output logic                   flush_done,
  output logic                   btb_wr_en,
  output logic [PC_BITS-1:0]     btb_orig_pc,
  output logic [PC_BITS-1:0]     btb_target_pc,
  output logic                   btb_invalidate,
  output logic [PC_BITS-1:0]     btb_pc_invalid
);

  localparam int SEL_BITS = $clog2(SIZE);
  localparam int CW       = $clog2(QUEUE_DEPTH + 1);
  localparam logic [SEL_BITS-1:0] LAST = SEL_BITS'(SIZE - 1);

  ctrl_state_e            state, state_d;
  logic [SEL_BITS-1:0]    cnt;
  btb_upd_t               head;
  logic                   head_valid;
  logic [CW-1:0]          count;
  logic [1:0]             push;
  btb_upd_t [1:0]         push_data;
  logic                   idle_go;
  logic                   clear;
  logic                   kill;
  logic                   hold;
  logic                   pop;
  logic [PKG_PC_BITS-1:0] inv_pc_w;

  assign inv_pc_w  = PKG_PC_BITS'(inv_pc);
  assign upd_ready = (state == IDLE) &&
                     (count <= CW'(QUEUE_DEPTH - 2));
  assign push      = upd_valid & {2{upd_ready}};
  assign idle_go   = (state == IDLE) && !flush_req;
  assign clear     = (state == IDLE) && flush_req;
  assign kill      = idle_go && inv_valid;

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      push_data[s].orig_pc   = PKG_PC_BITS'(upd_orig_pc[s]);
      push_data[s].target_pc = PKG_PC_BITS'(upd_target_pc[s]);
    end
  end

  // A same-line survivor waits a cycle so its write follows the invalidate.
  assign hold = kill && head_valid &&
                (line_idx(head.orig_pc, SEL_BITS) ==
                 line_idx(inv_pc_w, SEL_BITS));
  assign pop  = idle_go && head_valid && !hold;

  btb_upd_queue #(
    .DEPTH (QUEUE_DEPTH),
    .CW    (CW)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .kill       (kill),
    .kill_pc    (inv_pc_w),
    .pop        (pop),
    .push       (push),
    .push_data  (push_data),
    .head       (head),
    .head_valid (head_valid),
    .count      (count)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (flush_req) state_d = FLUSH;
      FLUSH:   if (cnt == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      flush_busy     <= 1'b0;
      flush_done     <= 1'b0;
      btb_wr_en      <= 1'b0;
      btb_orig_pc    <= '0;
      btb_target_pc  <= '0;
      btb_invalidate <= 1'b0;
      btb_pc_invalid <= '0;
    end else begin
      btb_wr_en  <= pop;
      flush_busy <= (state == FLUSH);
      flush_done <= (state == FLUSH) && (cnt == LAST);
      if (pop) begin
        btb_orig_pc   <= PC_BITS'(head.orig_pc);
        btb_target_pc <= PC_BITS'(head.target_pc);
      end
      if (state == FLUSH) begin
        btb_invalidate <= 1'b1;
        btb_pc_invalid <= PC_BITS'({cnt, 1'b0});
        cnt            <= cnt + 1'b1;
      end else begin
        btb_invalidate <= kill;
        if (kill) btb_pc_invalid <= inv_pc;
      end
    end
  end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl (SIZE=8, QUEUE_DEPTH=4).
// Expectations follow BTB_UPD_COALESCE_EN when it is defined.
module tb_btb_update_ctrl;

  logic             clk;
  logic             rst;
  logic [1:0]       upd_valid;
  logic [1:0][31:0] upd_orig_pc;
  logic [1:0][31:0] upd_target_pc;
  logic             upd_ready;
  logic             inv_valid;
  logic [31:0]      inv_pc;
  logic             flush_req;
  logic             flush_busy;
  logic             flush_done;
  logic             btb_wr_en;
  logic [31:0]      btb_orig_pc;
  logic [31:0]      btb_target_pc;
  logic             btb_invalidate;
  logic [31:0]      btb_pc_invalid;

  int checks;
  int failures;

  btb_update_ctrl #(
    .PC_BITS     (32),
    .SIZE        (8),
    .QUEUE_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .upd_valid      (upd_valid),
    .upd_orig_pc    (upd_orig_pc),
    .upd_target_pc  (upd_target_pc),
    .upd_ready      (upd_ready),
    .inv_valid      (inv_valid),
    .inv_pc         (inv_pc),
    .flush_req      (flush_req),
    .flush_busy     (flush_busy),
    .flush_done     (flush_done),
    .btb_wr_en      (btb_wr_en),
    .btb_orig_pc    (btb_orig_pc),
    .btb_target_pc  (btb_target_pc),
    .btb_invalidate (btb_invalidate),
    .btb_pc_invalid (btb_pc_invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    upd_valid     = 2'b00;
    upd_orig_pc   = '0;
    upd_target_pc = '0;
    inv_valid     = 1'b0;
    inv_pc        = '0;
    flush_req     = 1'b0;
  endtask

  task automatic upd(input logic [1:0]  v,
                     input logic [31:0] p0, input logic [31:0] t0,
                     input logic [31:0] p1, input logic [31:0] t1);
    upd_valid        = v;
    upd_orig_pc[0]   = p0;
    upd_target_pc[0] = t0;
    upd_orig_pc[1]   = p1;
    upd_target_pc[1] = t1;
  endtask

  task automatic inv(input logic [31:0] pc);
    inv_valid = 1'b1;
    inv_pc    = pc;
  endtask

  task automatic chk_wr(input string tag, input logic en,
                        input logic [31:0] pc,
                        input logic [31:0] tgt);
    chk({tag, "_en"}, 64'(btb_wr_en), 64'(en));
    if (en) begin
      chk({tag, "_pc"}, 64'(btb_orig_pc), 64'(pc));
      chk({tag, "_tgt"}, 64'(btb_target_pc), 64'(tgt));
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_wr", 64'(btb_wr_en), 64'd0);
    chk("rst_inv", 64'(btb_invalidate), 64'd0);
    chk("rst_busy", 64'(flush_busy), 64'd0);
    chk("rst_done", 64'(flush_done), 64'd0);
    chk("rst_ready", 64'(upd_ready), 64'd1);

    // Two updates drain in order, one per cycle.
    upd(2'b11, 32'h100, 32'h200, 32'h104, 32'h300);
    tick();
    idle_in();
    chk_wr("d0", 1'b0, 32'h0, 32'h0);
    tick();
    chk_wr("d1", 1'b1, 32'h100, 32'h200);
    tick();
    chk_wr("d2", 1'b1, 32'h104, 32'h300);
    tick();
    chk_wr("d3", 1'b0, 32'h0, 32'h0);

    // Fill to 3 entries while head is held by same-line invalidates.
    upd(2'b11, 32'h100, 32'h500, 32'h104, 32'h504);
    inv(32'h010);
    tick();
    upd(2'b01, 32'h108, 32'h508, 32'h0, 32'h0);
    inv(32'h010);
    chk("q2_ready", 64'(upd_ready), 64'd1);
    tick();
    idle_in();
    chk("q3_ready", 64'(upd_ready), 64'd0);
    chk("hold_inv", 64'(btb_invalidate), 64'd1);
    chk_wr("hold_wr", 1'b0, 32'h0, 32'h0);
    tick();
    chk_wr("q_pop0", 1'b1, 32'h100, 32'h500);
    chk("q_pop_ready", 64'(upd_ready), 64'd1);
    tick();
    chk_wr("q_pop1", 1'b1, 32'h104, 32'h504);
    tick();
    chk_wr("q_pop2", 1'b1, 32'h108, 32'h508);
    tick();
    chk_wr("q_empty", 1'b0, 32'h0, 32'h0);

    // Matching invalidate kills the queued head.
    upd(2'b01, 32'h100, 32'h200, 32'h0, 32'h0);
    tick();
    idle_in();
    inv(32'h100);
    tick();
    idle_in();
    chk("kill_inv", 64'(btb_invalidate), 64'd1);
    chk("kill_ipc", 64'(btb_pc_invalid), 64'h100);
    chk_wr("kill_wr0", 1'b0, 32'h0, 32'h0);
    tick();
    chk_wr("kill_wr1", 1'b0, 32'h0, 32'h0);

    // Update accepted alongside a matching invalidate is kept.
    upd(2'b01, 32'h100, 32'h280, 32'h0, 32'h0);
    inv(32'h100);
    tick();
    idle_in();
    chk("young_inv", 64'(btb_invalidate), 64'd1);
    chk_wr("young_wr0", 1'b0, 32'h0, 32'h0);
    tick();
    chk_wr("young_wr1", 1'b1, 32'h100, 32'h280);

    // Same line, different PC: invalidate first, write next cycle.
    upd(2'b01, 32'h802, 32'h900, 32'h0, 32'h0);
    tick();
    idle_in();
    inv(32'h002);
    tick();
    idle_in();
    chk("line_inv", 64'(btb_invalidate), 64'd1);
    chk("line_ipc", 64'(btb_pc_invalid), 64'h002);
    chk_wr("line_wr0", 1'b0, 32'h0, 32'h0);
    tick();
    chk("line_inv1", 64'(btb_invalidate), 64'd0);
    chk_wr("line_wr1", 1'b1, 32'h802, 32'h900);
    tick();

    // Flush with 3 queued entries: 8 invalidates, no writes.
    upd(2'b11, 32'h300, 32'h600, 32'h304, 32'h604);
    inv(32'h010);
    tick();
    upd(2'b01, 32'h308, 32'h608, 32'h0, 32'h0);
    inv(32'h010);
    tick();
    idle_in();
    flush_req = 1'b1;
    tick();
    idle_in();
    chk("fl_ready", 64'(upd_ready), 64'd0);
    chk_wr("fl_wr_req", 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("fl_inv%0d", i), 64'(btb_invalidate), 64'd1);
      chk($sformatf("fl_ipc%0d", i), 64'(btb_pc_invalid),
          64'(2 * i));
      chk($sformatf("fl_done%0d", i), 64'(flush_done),
          64'(i == 7));
      chk($sformatf("fl_busy%0d", i), 64'(flush_busy), 64'd1);
      chk($sformatf("fl_wr%0d", i), 64'(btb_wr_en), 64'd0);
    end
    tick();
    chk("fl_end_done", 64'(flush_done), 64'd0);
    chk("fl_end_busy", 64'(flush_busy), 64'd0);
    chk("fl_end_inv", 64'(btb_invalidate), 64'd0);
    chk("fl_end_ready", 64'(upd_ready), 64'd1);
    chk_wr("fl_end_wr", 1'b0, 32'h0, 32'h0);

    // Reset mid-sweep restarts the counter from 0.
    flush_req = 1'b1;
    tick();
    idle_in();
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", 64'(flush_busy), 64'd0);
    chk("mrst_done", 64'(flush_done), 64'd0);
    chk("mrst_inv", 64'(btb_invalidate), 64'd0);
    chk("mrst_ready", 64'(upd_ready), 64'd1);
    flush_req = 1'b1;
    tick();
    idle_in();
    tick();
    chk("mrst_ipc0", 64'(btb_pc_invalid), 64'h0);
    for (int i = 1; i < 8; i++) tick();
    chk("mrst_last_ipc", 64'(btb_pc_invalid), 64'hE);
    chk("mrst_last_done", 64'(flush_done), 64'd1);
    tick();

    // Second update to a queued PC.
    upd(2'b01, 32'h100, 32'h200, 32'h0, 32'h0);
    inv(32'h010);
    tick();
    upd(2'b01, 32'h100, 32'h240, 32'h0, 32'h0);
    inv(32'h010);
    tick();
    idle_in();
    tick();
`ifdef BTB_UPD_COALESCE_EN
    chk_wr("co_wr0", 1'b1, 32'h100, 32'h240);
    tick();
    chk_wr("co_wr1", 1'b0, 32'h0, 32'h0);
`else
    chk_wr("co_wr0", 1'b1, 32'h100, 32'h200);
    tick();
    chk_wr("co_wr1", 1'b1, 32'h100, 32'h240);
    tick();
    chk_wr("co_wr2", 1'b0, 32'h0, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
